// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - command, status and memory-port bundle for the copy/fill engine
interface mem_copy_engine_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] sum;
    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_wData;
    logic [DATA_W-1:0] mem_rData;

    modport slave (
        input  start, mode, src, dst, len, pattern, mem_rData,
        output busy, done, sum, mem_enable, mem_rw, mem_add, mem_wData
    );

    modport master (
        output start, mode, src, dst, len, pattern, mem_rData,
        input  busy, done, sum, mem_enable, mem_rw, mem_add, mem_wData
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word copy/fill engine over a single-port synchronous memory
module mem_copy_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_copy_engine_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              busy, done, mem_enable, mem_rw;
    logic [ADDR_W-1:0] mem_add, idx_inc;
    logic [DATA_W-1:0] mem_wdata, wr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        pattern_d  = pattern_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        data_d     = data_q;
        busy       = 1'b0;
        done       = 1'b0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_add    = '0;
        mem_wdata  = '0;
        wr_word    = mode_q ? pattern_q : data_q;
        idx_inc    = idx_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    src_d     = bus.src;
                    dst_d     = bus.dst;
                    len_d     = bus.len;
                    pattern_d = bus.pattern;
                    idx_d     = '0;
                    sum_d     = '0;
                    if (bus.len == '0)
                        state_d = ST_DONE;
                    else
                        state_d = bus.mode ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_add    = src_q + idx_q;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Memory registers read data on the edge that ends READ.
                busy    = 1'b1;
                data_d  = bus.mem_rData;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_rw     = 1'b1;
                mem_add    = dst_q + idx_q;
                mem_wdata  = wr_word;
                sum_d      = sum_q + wr_word;
                idx_d      = idx_inc;
                if (idx_inc == len_q)
                    state_d = ST_DONE;
                else
                    state_d = mode_q ? ST_WRITE : ST_READ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.sum        = sum_q;
    assign bus.mem_enable = mem_enable;
    assign bus.mem_rw     = mem_rw;
    assign bus.mem_add    = mem_add;
    assign bus.mem_wData  = mem_wdata;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine with memory and reference model
module tb_mem_copy_engine;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) ifc();
    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];
    int tests = 0;
    int fails = 0;

    always @(posedge clk) begin
        if (ifc.mem_enable && ifc.mem_rw)  mem[ifc.mem_add] <= ifc.mem_wData;
        if (ifc.mem_enable && !ifc.mem_rw) ifc.mem_rData <= mem[ifc.mem_add];
    end

    typedef struct {
        logic          mode;
        int            src;
        int            dst;
        int            len;
        logic [DW-1:0] pattern;
        logic [DW-1:0] exp_sum;
        int            exp_done;
        int            exp_en;
        int            chk_addr;
        logic [DW-1:0] chk_val;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mem_check(input string name);
        int mism = 0;
        int first = -1;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== ref_mem[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        if (mism != 0) $display("  first differing word at %0d: %0h vs %0h", first, mem[first], ref_mem[first]);
        check(name, 64'(mism), 64'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  64'(ifc.busy),       64'(0));
        check({tag, "_done"},  64'(ifc.done),       64'(0));
        check({tag, "_en"},    64'(ifc.mem_enable), 64'(0));
        check({tag, "_rw"},    64'(ifc.mem_rw),     64'(0));
        check({tag, "_add"},   64'(ifc.mem_add),    64'(0));
        check({tag, "_wdata"}, 64'(ifc.mem_wData),  64'(0));
    endtask

    task automatic run_op(input logic m, input int s, input int d, input int n,
                          input logic [DW-1:0] p, input int poke,
                          output int done_cyc, output int en_cnt, output logic [DW-1:0] sum_v);
        logic [DW-1:0] exp_sum;
        logic [DW-1:0] w;
        int exp_done;
        int busy_cnt;
        int cyc;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = m ? p : ref_mem[(s + i) % NW];
            ref_mem[(d + i) % NW] = w;
            exp_sum += w;
        end
        exp_done = (n == 0) ? 1 : (m ? n + 1 : 3 * n + 1);
        done_cyc = 0;
        en_cnt   = 0;
        busy_cnt = 0;
        cyc      = 0;

        @(negedge clk);
        ifc.start   = 1'b1;
        ifc.mode    = m;
        ifc.src     = AW'(s);
        ifc.dst     = AW'(d);
        ifc.len     = AW'(n);
        ifc.pattern = p;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        while (done_cyc == 0 && cyc < 3 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (ifc.mem_enable) en_cnt++;
            if (ifc.busy) busy_cnt++;
            if (ifc.done) done_cyc = cyc;
            if (poke != 0 && cyc == poke) begin
                ifc.start = 1'b1;
                ifc.mode  = ~m;
                ifc.dst   = ifc.dst + 1'b1;
                ifc.len   = AW'(5);
            end
            if (poke != 0 && cyc == poke + 1) ifc.start = 1'b0;
        end
        sum_v = ifc.sum;
        check("done_cycle",    64'(done_cyc), 64'(exp_done));
        check("enable_cycles", 64'(en_cnt),   64'(m ? n : 2 * n));
        check("busy_cycles",   64'(busy_cnt), 64'(exp_done - 1));
        check("sum",           64'(ifc.sum),  64'(exp_sum));
        mem_check("mem_image");
        @(negedge clk);
        check("done_one_cycle", 64'(ifc.done), 64'(0));
        check("sum_hold",       64'(ifc.sum),  64'(exp_sum));
        check("idle_busy",      64'(ifc.busy), 64'(0));
    endtask

    initial begin
        vec_t vecs[6];
        int dc, ec;
        logic [DW-1:0] sv;
        int s, d, n;
        logic m;

        vecs[0] = '{1'b0, 0,    100, 3, 32'h0,        32'h22,       10, 6, 102,  32'h11};
        vecs[1] = '{1'b1, 0,    500, 4, 32'hA5A5A5A5, 32'h96969694, 5,  4, 503,  32'hA5A5A5A5};
        vecs[2] = '{1'b0, 1022, 10,  3, 32'h0,        32'h10,       10, 6, 12,   32'h1};
        vecs[3] = '{1'b0, 5,    200, 0, 32'h0,        32'h0,        1,  0, 200,  32'h55};
        vecs[4] = '{1'b1, 0,    1023,1, 32'h12345678, 32'h12345678, 2,  1, 1023, 32'h12345678};
        vecs[5] = '{1'b1, 0,    1022,3, 32'h1,        32'h3,        4,  3, 0,    32'h1};

        for (int i = 0; i < NW; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h1;  mem[1] = 32'h10; mem[2] = 32'h11;
        mem[1022] = 32'h7; mem[1023] = 32'h8; mem[200] = 32'h55;
        ref_mem[0] = 32'h1;  ref_mem[1] = 32'h10; ref_mem[2] = 32'h11;
        ref_mem[1022] = 32'h7; ref_mem[1023] = 32'h8; ref_mem[200] = 32'h55;

        ifc.start = 1'b0; ifc.mode = 1'b0; ifc.src = '0; ifc.dst = '0;
        ifc.len = '0; ifc.pattern = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_sum", 64'(ifc.sum), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].pattern, 0, dc, ec, sv);
            check($sformatf("vec%0d_sum", i),  64'(sv), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_done", i), 64'(dc), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_en", i),   64'(ec), 64'(vecs[i].exp_en));
            check($sformatf("vec%0d_word", i), 64'(mem[vecs[i].chk_addr]), 64'(vecs[i].chk_val));
        end

        run_op(1'b0, 0, 700, 3, 32'h0, 2, dc, ec, sv);
        check("busy_start_sum",  64'(sv), 64'(32'h22));
        check("busy_start_done", 64'(dc), 64'(10));
        check("busy_start_word", 64'(mem[702]), 64'(32'h11));

        mem[100] = 32'hDEAD0000; mem[101] = 32'hDEAD0001; mem[102] = 32'hDEAD0002;
        ref_mem[100] = 32'hDEAD0000; ref_mem[101] = 32'hDEAD0001; ref_mem[102] = 32'hDEAD0002;
        @(negedge clk);
        ifc.start = 1'b1; ifc.mode = 1'b0; ifc.src = '0; ifc.dst = AW'(100); ifc.len = AW'(3);
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_read_en", 64'({ifc.mem_enable, ifc.mem_rw}), 64'(2'b10));
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midop_reset");
        check("midop_sum", 64'(ifc.sum), 64'(0));
        reset = 1'b0;
        ref_mem[100] = ref_mem[0];
        mem_check("midop_mem");
        check("midop_unwritten", 64'(mem[101]), 64'(32'hDEAD0001));
        run_op(1'b0, 0, 100, 3, 32'h0, 0, dc, ec, sv);
        check("after_reset_sum", 64'(sv), 64'(32'h22));

        @(negedge clk);
        reset = 1'b1;
        ifc.start = 1'b1; ifc.mode = 1'b1; ifc.dst = AW'(900); ifc.len = AW'(3);
        @(negedge clk);
        reset = 1'b0;
        ifc.start = 1'b0;
        check("start_with_reset_busy", 64'(ifc.busy), 64'(0));
        @(negedge clk);
        check("start_with_reset_idle", 64'(ifc.busy), 64'(0));
        mem_check("start_with_reset_mem");

        for (int k = 0; k < 24; k++) begin
            m = 1'($urandom_range(0, 1));
            s = $urandom_range(0, NW - 1);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 300) : $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0)
                d = (s + $urandom_range(1, 3)) % NW;
            else
                d = $urandom_range(0, NW - 1);
            run_op(m, s, d, n, $urandom, 0, dc, ec, sv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
